// File: rtl/loopback_checker.sv
// Loopback checker: queues sent words and compares each received word against the oldest
// queued word. First-mismatch capture is built only with LOOPBACK_CHECKER_FIRST_ERR_EN.
module loopback_checker #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     tx_valid,
  input  logic [WIDTH-1:0]         tx_data,
  output logic                     tx_ready,
  input  logic                     rx_valid,
  input  logic [WIDTH-1:0]         rx_data,
  output logic                     result_valid,
  output logic                     match,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     overflow,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   level
`ifdef LOOPBACK_CHECKER_FIRST_ERR_EN
  ,
  output logic                     first_err_valid,
  output logic [WIDTH-1:0]         first_err_exp,
  output logic [WIDTH-1:0]         first_err_got
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_result_valid_p1;
  logic             r_match_p1;
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_rx;
  logic             w_match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);
  assign w_rx    = rx_valid && !clear;
  assign w_push  = tx_valid && !w_full && !clear;
  assign w_pop   = w_rx && !w_empty;
  // An underflow never matches, even if a word is being pushed in the same cycle.
  assign w_match = w_pop && (r_mem[r_rptr] == rx_data);

  // Storage carries no reset; reads are gated by level so stale words are never compared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_wptr            <= '0;
      r_rptr            <= '0;
      r_level           <= '0;
      r_result_valid_p1 <= 1'b0;
      r_match_p1        <= 1'b0;
      r_match_cnt       <= '0;
      r_err_cnt         <= '0;
      r_overflow        <= 1'b0;
      r_underflow       <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // ---- stage p1: registered compare result, counters move with it
      r_result_valid_p1 <= w_rx;
      r_match_p1        <= w_match;
      if (w_rx && w_match)  r_match_cnt <= sat_inc(r_match_cnt);
      if (w_rx && !w_match) r_err_cnt   <= sat_inc(r_err_cnt);
      if (tx_valid && w_full) r_overflow  <= 1'b1;
      if (w_rx && w_empty)    r_underflow <= 1'b1;
    end
  end

`ifdef LOOPBACK_CHECKER_FIRST_ERR_EN
  logic             r_first_err_valid;
  logic [WIDTH-1:0] r_first_err_exp;
  logic [WIDTH-1:0] r_first_err_got;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_first_err_valid <= 1'b0;
      r_first_err_exp   <= '0;
      r_first_err_got   <= '0;
    end else if (w_rx && !w_match && !r_first_err_valid) begin
      r_first_err_valid <= 1'b1;
      r_first_err_exp   <= w_pop ? r_mem[r_rptr] : '0;
      r_first_err_got   <= rx_data;
    end
  end

  assign first_err_valid = r_first_err_valid;
  assign first_err_exp   = r_first_err_exp;
  assign first_err_got   = r_first_err_got;
`endif

  assign tx_ready     = !w_full;
  assign result_valid = r_result_valid_p1;
  assign match        = r_match_p1;
  assign match_cnt    = r_match_cnt;
  assign err_cnt      = r_err_cnt;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign level        = r_level;

endmodule

// File: tb/tb_loopback_checker.sv
// Directed bench for loopback_checker (WIDTH=23, DEPTH=8, CNT_W=4 so saturation is reachable).
module tb_loopback_checker;

  localparam int WIDTH = 23;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, clear, tx_valid, rx_valid;
  logic [WIDTH-1:0] tx_data, rx_data;
  logic             tx_ready, result_valid, match, overflow, underflow;
  logic [CNT_W-1:0] match_cnt, err_cnt;
  logic [3:0]       level;
`ifdef LOOPBACK_CHECKER_FIRST_ERR_EN
  logic             first_err_valid;
  logic [WIDTH-1:0] first_err_exp, first_err_got;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  loopback_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .result_valid(result_valid), .match(match),
    .match_cnt(match_cnt), .err_cnt(err_cnt),
    .overflow(overflow), .underflow(underflow), .level(level)
`ifdef LOOPBACK_CHECKER_FIRST_ERR_EN
    , .first_err_valid(first_err_valid), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    tx_valid = 1'b0; rx_valid = 1'b0; clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle(); tx_data = '0; rx_data = '0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_rv", 32'(result_valid), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_mcnt", 32'(match_cnt), 0);
    chk("rst_ecnt", 32'(err_cnt), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);

    // three pushes then three matching receives
    tx_valid = 1'b1;
    tx_data = 23'h000001; step();
    tx_data = 23'h7FFFFF; step();
    tx_data = 23'h2AAAAA; step();
    tx_valid = 1'b0;
    chk("push3_level", 32'(level), 3);
    chk("push3_rv", 32'(result_valid), 0);
    rx_valid = 1'b1;
    rx_data = 23'h000001; step();
    chk("rx1_rv", 32'(result_valid), 1);
    chk("rx1_match", 32'(match), 1);
    chk("rx1_mcnt", 32'(match_cnt), 1);
    rx_data = 23'h7FFFFF; step();
    chk("rx2_match", 32'({result_valid, match}), 3);
    rx_data = 23'h2AAAAA; step();
    chk("rx3_match", 32'({result_valid, match}), 3);
    rx_valid = 1'b0; step();
    chk("rx_done_rv", 32'(result_valid), 0);
    chk("rx_done_mcnt", 32'(match_cnt), 3);
    chk("rx_done_ecnt", 32'(err_cnt), 0);
    chk("rx_done_level", 32'(level), 0);

    // single-bit mismatch
    tx_valid = 1'b1; tx_data = 23'h123456; step();
    tx_valid = 1'b0; rx_valid = 1'b1; rx_data = 23'h123457; step();
    rx_valid = 1'b0;
    chk("mis_rv", 32'(result_valid), 1);
    chk("mis_match", 32'(match), 0);
    chk("mis_ecnt", 32'(err_cnt), 1);
    chk("mis_mcnt", 32'(match_cnt), 3);
`ifdef LOOPBACK_CHECKER_FIRST_ERR_EN
    chk("fe_valid", 32'(first_err_valid), 1);
    chk("fe_exp", 32'(first_err_exp), 32'h123456);
    chk("fe_got", 32'(first_err_got), 32'h123457);
`endif
    step();

    // underflow with same-cycle push: no bypass
    tx_valid = 1'b1; tx_data = 23'h000005; rx_valid = 1'b1; rx_data = 23'h000005; step();
    tx_valid = 1'b0;
    chk("unf_rv_match", 32'({result_valid, match}), 2);
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_ecnt", 32'(err_cnt), 2);
    chk("unf_level", 32'(level), 1);
`ifdef LOOPBACK_CHECKER_FIRST_ERR_EN
    chk("fe_hold", 32'(first_err_exp), 32'h123456);
`endif
    step();
    rx_valid = 1'b0;
    chk("unf_next_match", 32'({result_valid, match}), 3);
    chk("unf_next_mcnt", 32'(match_cnt), 4);
    chk("unf_next_level", 32'(level), 0);
    chk("unf_sticky", 32'(underflow), 1);

    // fill past full; pointers wrap during this pass
    tx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_data = 23'(32'h100 + i); step();
    end
    chk("full_ready", 32'(tx_ready), 0);
    chk("full_level", 32'(level), 8);
    chk("full_ovf0", 32'(overflow), 0);
    tx_data = 23'h000108; step();
    tx_valid = 1'b0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 8);
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 23'(32'h100 + i); step();
      chk("drain_match", 32'({result_valid, match}), 3);
    end
    rx_valid = 1'b0;
    chk("drain_mcnt", 32'(match_cnt), 12);
    chk("drain_level", 32'(level), 0);
    chk("drain_ready", 32'(tx_ready), 1);

    // simultaneous push and pop keeps level
    tx_valid = 1'b1; tx_data = 23'h000055; step();
    tx_data = 23'h000066; rx_valid = 1'b1; rx_data = 23'h000055; step();
    tx_valid = 1'b0;
    chk("pp_level", 32'(level), 1);
    chk("pp_match", 32'({result_valid, match}), 3);
    rx_data = 23'h000066; step();
    rx_valid = 1'b0;
    chk("pp2_match", 32'({result_valid, match}), 3);
    chk("pp2_mcnt", 32'(match_cnt), 14);

    // reset mid-operation with level=5 and a result pending
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 23'(32'h200 + i); step();
    end
    tx_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 5);
    rx_valid = 1'b1; rx_data = 23'h000200; rst_n = 1'b0; step();
    rx_valid = 1'b0; rst_n = 1'b1;
    chk("mrst_rv", 32'(result_valid), 0);
    chk("mrst_level", 32'(level), 0);
    chk("mrst_ready", 32'(tx_ready), 1);
    chk("mrst_flags", 32'({overflow, underflow}), 0);
    chk("mrst_mcnt", 32'(match_cnt), 0);
    step();
    chk("mrst_rv2", 32'(result_valid), 0);

    // 20 mismatches saturate err_cnt at 15
    for (int i = 0; i < 20; i++) begin
      tx_valid = 1'b1; tx_data = 23'(32'h300 + i); step();
      tx_valid = 1'b0; rx_valid = 1'b1; rx_data = 23'(32'h7300 + i); step();
      rx_valid = 1'b0;
    end
    chk("sat_ecnt", 32'(err_cnt), 15);
    chk("sat_mcnt", 32'(match_cnt), 0);
    chk("sat_unf", 32'(underflow), 0);
`ifdef LOOPBACK_CHECKER_FIRST_ERR_EN
    chk("sat_fe_exp", 32'(first_err_exp), 32'h300);
`endif
    rx_valid = 1'b1; rx_data = 23'h000001; step();
    rx_valid = 1'b0;
    chk("sat_unf_flag", 32'(underflow), 1);
    chk("sat_hold", 32'(err_cnt), 15);
    tx_valid = 1'b1; tx_data = 23'h000009; step();
    chk("pre_clr_level", 32'(level), 1);

    // clear with tx and rx active: everything goes to zero
    clear = 1'b1; rx_valid = 1'b1; rx_data = 23'h000009; step();
    idle();
    chk("clr_level", 32'(level), 0);
    chk("clr_ecnt", 32'(err_cnt), 0);
    chk("clr_mcnt", 32'(match_cnt), 0);
    chk("clr_flags", 32'({overflow, underflow}), 0);
    chk("clr_rv", 32'(result_valid), 0);
`ifdef LOOPBACK_CHECKER_FIRST_ERR_EN
    chk("clr_fe", 32'(first_err_valid), 0);
`endif
    step();
    chk("clr_rv2", 32'(result_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
